// File: rtl/peripheral_uart_pkg.sv
// Shared UART types and helpers for the receiver and transmitter.
package peripheral_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP1     = 3'd4,
    STOP2     = 3'd5,
    DONE      = 3'd6,
    WAIT_HIGH = 3'd7
  } uart_rx_state_t;

  localparam int unsigned MAX_DATA_BITS = 8;

  // Data-bit count selected by cfg_bits: 00/01/10/11 -> 5/6/7/8.
  function automatic logic [3:0] uart_data_bits(input logic [1:0] cfg_bits);
    return 4'd5 + {2'b00, cfg_bits};
  endfunction

endpackage

// File: rtl/peripheral_uart_sync.sv
// Metastability synchroniser for the asynchronous serial line; resets to idle (1).
module peripheral_uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART receiver: mid-bit sampling, 5-8 data bits LSB first, optional even parity,
// 1 or 2 stop bits, valid/ready output and sticky parity/frame/overrun flags.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | waiting for mid start bit to confirm it is not a glitch
// DATA      | sampling data bits
// PARITY    | sampling the even-parity bit
// STOP1     | sampling the first stop bit
// STOP2     | sampling the second stop bit
// DONE      | one clock: load output register
// WAIT_HIGH | line held low (break), wait for it to return high
module peripheral_uart_rx
  import peripheral_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o,
  input  logic        err_clr_i
);

  uart_rx_state_t state, state_nxt;

  logic        rx_s;
  logic        rx_d;
  logic        fall;
  logic [15:0] cnt;
  logic [15:0] half;
  logic        sample;
  logic [2:0]  bit_cnt;
  logic        bit_last;
  logic [3:0]  n_bits;
  logic [7:0]  shift_reg;
  logic [7:0]  data_aligned;
  logic        shift_en;
  logic        load;
  logic        par_err_set;
  logic        frm_err_set;
  logic        ovr_err_set;

  peripheral_uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // Delay flop for falling-edge detection on the synchronised line.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_d <= 1'b1;
    else         rx_d <= rx_s;
  end

  assign fall         = rx_d & ~rx_s;
  assign half         = cfg_div_i >> 1;
  assign n_bits       = uart_data_bits(cfg_bits_i);
  assign bit_last     = ({1'b0, bit_cnt} == (n_bits - 4'd1));
  assign sample       = (state == START) ? (cnt == half) : (cnt == cfg_div_i);
  assign data_aligned = shift_reg >> (4'd8 - n_bits);
  assign ovr_err_set  = load & rx_valid_o & ~rx_ready_i;
  assign busy_o       = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and per-sample actions. The edge-detect cycle counts as
  // baud tick 0 of the start bit, so with half == 0 the start bit is already
  // confirmed there and the FSM goes straight to DATA.
  always_comb begin
    state_nxt   = state;
    shift_en    = 1'b0;
    load        = 1'b0;
    par_err_set = 1'b0;
    frm_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_en_i && fall) state_nxt = (half == 16'd0) ? DATA : START;
      end
      START: begin
        if (sample) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_last) state_nxt = cfg_parity_en_i ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (sample) begin
          par_err_set = (rx_s != ^shift_reg);
          state_nxt   = STOP1;
        end
      end
      STOP1: begin
        if (sample) begin
          frm_err_set = ~rx_s;
          state_nxt   = cfg_stop_bits_i ? STOP2 : DONE;
        end
      end
      STOP2: begin
        if (sample) begin
          frm_err_set = ~rx_s;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        load      = 1'b1;
        state_nxt = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_nxt   = IDLE;
      shift_en    = 1'b0;
      load        = 1'b0;
      par_err_set = 1'b0;
      frm_err_set = 1'b0;
    end
  end

  // Baud counter: held at 0 in IDLE, restarts after every sample point.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= 16'd0;
    end else begin
      case (state)
        IDLE:                             cnt <= (cfg_en_i && fall && half != 16'd0) ? 16'd1 : 16'd0;
        START, DATA, PARITY, STOP1, STOP2: cnt <= sample ? 16'd0 : cnt + 16'd1;
        default:                          cnt <= 16'd0;
      endcase
    end
  end

  // Data shift register (new bit at MSB) and data-bit counter; cleared in IDLE
  // so unused low bits stay 0 and the parity XOR covers only received bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shift_reg <= 8'd0;
      bit_cnt   <= 3'd0;
    end else if (shift_en) begin
      shift_reg <= {rx_s, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 3'd1;
    end else if (state == IDLE) begin
      shift_reg <= 8'd0;
      bit_cnt   <= 3'd0;
    end else if (state != DATA) begin
      bit_cnt   <= 3'd0;
    end
  end

  // Output register with valid/ready handshake; a new char always overwrites.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_data_o  <= 8'd0;
      rx_valid_o <= 1'b0;
    end else if (load) begin
      rx_data_o  <= data_aligned;
      rx_valid_o <= 1'b1;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      err_parity_o  <= par_err_set | (err_parity_o  & ~err_clr_i);
      err_frame_o   <= frm_err_set | (err_frame_o   & ~err_clr_i);
      err_overrun_o <= ovr_err_set | (err_overrun_o & ~err_clr_i);
    end
  end

endmodule
